// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types for the ID/EX operand stage: operand selects, the registered
// ID/EX bundle and its bubble value.
package pipeline_pkg;

    localparam int DATAWIDTH   = 32;
    localparam int REG_AW      = 5;
    localparam int SHIFT_WIDTH = 5;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'b00,
        SRCA_PC   = 2'b01,
        SRCA_ZERO = 2'b10
    } srca_sel_e;

    typedef enum logic {
        SRCB_RS2 = 1'b0,
        SRCB_IMM = 1'b1
    } srcb_sel_e;

    localparam logic [2:0] BRANCH_NONE = 3'b111;
    localparam logic [3:0] ALU_ADD     = 4'b0000;

    typedef struct packed {
        logic                 valid;
        logic [DATAWIDTH-1:0] rs1_data;
        logic [DATAWIDTH-1:0] rs2_data;
        logic [DATAWIDTH-1:0] imm;
        logic [DATAWIDTH-1:0] pc;
        logic [REG_AW-1:0]    rs1_addr;
        logic [REG_AW-1:0]    rs2_addr;
        logic [REG_AW-1:0]    rd_addr;
        logic [3:0]           alu_ctrl;
        logic [2:0]           branch_ctrl;
        srca_sel_e            srca_sel;
        srcb_sel_e            srcb_sel;
        logic                 shamt_imm;
        logic                 reg_write;
        logic                 mem_read;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '{
        valid:       1'b0,
        rs1_data:    '0,
        rs2_data:    '0,
        imm:         '0,
        pc:          '0,
        rs1_addr:    '0,
        rs2_addr:    '0,
        rd_addr:     '0,
        alu_ctrl:    ALU_ADD,
        branch_ctrl: BRANCH_NONE,
        srca_sel:    SRCA_RS1,
        srcb_sel:    SRCB_RS2,
        shamt_imm:   1'b0,
        reg_write:   1'b0,
        mem_read:    1'b0
    };

    // A bypass source matches only when it writes, targets q, and q is not x0.
    function automatic logic bypass_hit(input logic             wr,
                                        input logic [REG_AW-1:0] rd,
                                        input logic [REG_AW-1:0] q);
        return wr && (rd == q) && (q != '0);
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode/hazard-control side of the ID/EX operand stage: ID bundle, bypass
// taps from later stages, and the operands driven into the ALU.
interface id_ex_operand_stage_if;
    import pipeline_pkg::*;

    logic                   stall_i;
    logic                   flush_i;

    logic                   id_valid_i;
    logic [DATAWIDTH-1:0]   id_rs1_data_i;
    logic [DATAWIDTH-1:0]   id_rs2_data_i;
    logic [DATAWIDTH-1:0]   id_imm_i;
    logic [DATAWIDTH-1:0]   id_pc_i;
    logic [REG_AW-1:0]      id_rs1_addr_i;
    logic [REG_AW-1:0]      id_rs2_addr_i;
    logic [REG_AW-1:0]      id_rd_addr_i;
    logic [3:0]             id_alu_ctrl_i;
    logic [2:0]             id_branch_ctrl_i;
    logic [1:0]             id_srca_sel_i;
    logic                   id_srcb_sel_i;
    logic                   id_shamt_imm_i;
    logic                   id_reg_write_i;
    logic                   id_mem_read_i;

    logic [REG_AW-1:0]      exmem_rd_addr_i;
    logic                   exmem_reg_write_i;
    logic [DATAWIDTH-1:0]   exmem_result_i;
    logic [REG_AW-1:0]      memwb_rd_addr_i;
    logic                   memwb_reg_write_i;
    logic [DATAWIDTH-1:0]   memwb_result_i;

    logic [DATAWIDTH-1:0]   SrcA_o;
    logic [DATAWIDTH-1:0]   SrcB_o;
    logic [3:0]             ALUctrl_o;
    logic [2:0]             BranchCtrl_o;
    logic [SHIFT_WIDTH-1:0] shift_o;
    logic                   ex_valid_o;
    logic [REG_AW-1:0]      ex_rd_addr_o;
    logic                   ex_reg_write_o;
    logic                   ex_mem_read_o;
    logic [DATAWIDTH-1:0]   ex_store_data_o;
    logic [DATAWIDTH-1:0]   ex_pc_o;
    logic                   load_use_o;

    modport master (
        output stall_i, flush_i,
        output id_valid_i, id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i,
        output id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
        output id_alu_ctrl_i, id_branch_ctrl_i, id_srca_sel_i, id_srcb_sel_i,
        output id_shamt_imm_i, id_reg_write_i, id_mem_read_i,
        output exmem_rd_addr_i, exmem_reg_write_i, exmem_result_i,
        output memwb_rd_addr_i, memwb_reg_write_i, memwb_result_i,
        input  SrcA_o, SrcB_o, ALUctrl_o, BranchCtrl_o, shift_o,
        input  ex_valid_o, ex_rd_addr_o, ex_reg_write_o, ex_mem_read_o,
        input  ex_store_data_o, ex_pc_o, load_use_o
    );

    modport slave (
        input  stall_i, flush_i,
        input  id_valid_i, id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i,
        input  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
        input  id_alu_ctrl_i, id_branch_ctrl_i, id_srca_sel_i, id_srcb_sel_i,
        input  id_shamt_imm_i, id_reg_write_i, id_mem_read_i,
        input  exmem_rd_addr_i, exmem_reg_write_i, exmem_result_i,
        input  memwb_rd_addr_i, memwb_reg_write_i, memwb_result_i,
        output SrcA_o, SrcB_o, ALUctrl_o, BranchCtrl_o, shift_o,
        output ex_valid_o, ex_rd_addr_o, ex_reg_write_o, ex_mem_read_o,
        output ex_store_data_o, ex_pc_o, load_use_o
    );

endinterface

// File: rtl/id_ex_operand_stage_forward_mux.sv
// RAW bypass for one source operand: EX/MEM beats MEM/WB, x0 never forwarded.
// Latency: combinational. Backpressure: none.
module forward_mux
    import pipeline_pkg::*;
(
    input  logic [REG_AW-1:0]    addr,
    input  logic [DATAWIDTH-1:0] reg_data,
    input  logic [REG_AW-1:0]    exmem_rd_addr,
    input  logic                 exmem_reg_write,
    input  logic [DATAWIDTH-1:0] exmem_result,
    input  logic [REG_AW-1:0]    memwb_rd_addr,
    input  logic                 memwb_reg_write,
    input  logic [DATAWIDTH-1:0] memwb_result,
    output logic [DATAWIDTH-1:0] fwd_data
);

    always_comb begin
        fwd_data = reg_data;
        if (bypass_hit(exmem_reg_write, exmem_rd_addr, addr)) begin
            fwd_data = exmem_result;
        end else if (bypass_hit(memwb_reg_write, memwb_rd_addr, addr)) begin
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with operand forwarding and ALU operand selection.
// Latency: 1 cycle ID->EX; forwarding and load_use are combinational.
// Backpressure: stall holds the register, flush (higher priority) loads a bubble.
module id_ex_operand_stage
    import pipeline_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    id_ex_operand_stage_if.slave bus
);

    id_ex_t               ex_q;
    id_ex_t               ex_d;
    logic [DATAWIDTH-1:0] rs1_fwd;
    logic [DATAWIDTH-1:0] rs2_fwd;

    always_comb begin
        ex_d = ex_q;
        if (bus.flush_i) begin
            ex_d = ID_EX_BUBBLE;
        end else if (!bus.stall_i) begin
            if (!bus.id_valid_i) begin
                ex_d = ID_EX_BUBBLE;
            end else begin
                ex_d.valid       = 1'b1;
                ex_d.rs1_data    = bus.id_rs1_data_i;
                ex_d.rs2_data    = bus.id_rs2_data_i;
                ex_d.imm         = bus.id_imm_i;
                ex_d.pc          = bus.id_pc_i;
                ex_d.rs1_addr    = bus.id_rs1_addr_i;
                ex_d.rs2_addr    = bus.id_rs2_addr_i;
                ex_d.rd_addr     = bus.id_rd_addr_i;
                ex_d.alu_ctrl    = bus.id_alu_ctrl_i;
                ex_d.branch_ctrl = bus.id_branch_ctrl_i;
                ex_d.srca_sel    = srca_sel_e'(bus.id_srca_sel_i);
                ex_d.srcb_sel    = srcb_sel_e'(bus.id_srcb_sel_i);
                ex_d.shamt_imm   = bus.id_shamt_imm_i;
                ex_d.reg_write   = bus.id_reg_write_i;
                ex_d.mem_read    = bus.id_mem_read_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_q <= ID_EX_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    forward_mux u_fwd_rs1 (
        .addr            (ex_q.rs1_addr),
        .reg_data        (ex_q.rs1_data),
        .exmem_rd_addr   (bus.exmem_rd_addr_i),
        .exmem_reg_write (bus.exmem_reg_write_i),
        .exmem_result    (bus.exmem_result_i),
        .memwb_rd_addr   (bus.memwb_rd_addr_i),
        .memwb_reg_write (bus.memwb_reg_write_i),
        .memwb_result    (bus.memwb_result_i),
        .fwd_data        (rs1_fwd)
    );

    forward_mux u_fwd_rs2 (
        .addr            (ex_q.rs2_addr),
        .reg_data        (ex_q.rs2_data),
        .exmem_rd_addr   (bus.exmem_rd_addr_i),
        .exmem_reg_write (bus.exmem_reg_write_i),
        .exmem_result    (bus.exmem_result_i),
        .memwb_rd_addr   (bus.memwb_rd_addr_i),
        .memwb_reg_write (bus.memwb_reg_write_i),
        .memwb_result    (bus.memwb_result_i),
        .fwd_data        (rs2_fwd)
    );

    // The unused select encoding 11 falls into the zero operand.
    always_comb begin
        bus.SrcA_o = '0;
        case (ex_q.srca_sel)
            SRCA_RS1: bus.SrcA_o = rs1_fwd;
            SRCA_PC:  bus.SrcA_o = ex_q.pc;
            default:  bus.SrcA_o = '0;
        endcase
    end

    assign bus.SrcB_o          = (ex_q.srcb_sel == SRCB_IMM) ? ex_q.imm : rs2_fwd;
    assign bus.shift_o         = ex_q.shamt_imm ? ex_q.imm[SHIFT_WIDTH-1:0]
                                                : rs2_fwd[SHIFT_WIDTH-1:0];
    assign bus.ex_store_data_o = rs2_fwd;
    assign bus.ALUctrl_o       = ex_q.alu_ctrl;
    assign bus.BranchCtrl_o    = ex_q.branch_ctrl;
    assign bus.ex_valid_o      = ex_q.valid;
    assign bus.ex_rd_addr_o    = ex_q.rd_addr;
    assign bus.ex_reg_write_o  = ex_q.reg_write;
    assign bus.ex_mem_read_o   = ex_q.mem_read;
    assign bus.ex_pc_o         = ex_q.pc;

    // A load in EX cannot be bypassed to the instruction now in decode.
    assign bus.load_use_o = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0)
                            && ((ex_q.rd_addr == bus.id_rs1_addr_i)
                             || (ex_q.rd_addr == bus.id_rs2_addr_i));

endmodule
